rdma2_ar_issue: RTL and testbench

- Downstream consumer of the RDMA2 address FIFO.
- Pops word-aligned read start addresses from the FWFT address FIFO and issues AXI4 read-address (AR) bursts toward the DDR interconnect.
- Bounds the number of in-flight bursts and retires them on R-channel last beats.
- Feeds the RDMA2 read data path: the R channel itself is only observed here, never driven.

---
 rtl/rdma2_ar_issue_if.sv | 34 +++
 rtl/rdma2_ar_issue.sv | 158 +++++++++++++++
 tb/tb_rdma2_ar_issue.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rdma2_ar_issue_if.sv
// Bundle between rdma2_ar_issue and its neighbours.
// It carries the FWFT address FIFO side, the AXI4 AR channel and the observed R handshake.
interface rdma2_ar_issue_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] fifo_data;
    logic              fifo_empty_n;
    logic              fifo_valid;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic              m_axi_rvalid;
    logic              m_axi_rready;
    logic              m_axi_rlast;

    // The issuer's view of the bundle.
    modport master (
        input  fifo_data, fifo_empty_n, m_axi_arready,
        input  m_axi_rvalid, m_axi_rready, m_axi_rlast,
        output fifo_valid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
        output m_axi_arburst, m_axi_arvalid
    );

    // The view from the FIFO, the interconnect and the read data path.
    modport slave (
        output fifo_data, fifo_empty_n, m_axi_arready,
        output m_axi_rvalid, m_axi_rready, m_axi_rlast,
        input  fifo_valid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
        input  m_axi_arburst, m_axi_arvalid
    );
endinterface

// File: rtl/rdma2_ar_issue.sv
// RDMA2 AR issuer: pops FIFO addresses and issues AXI4 INCR read bursts while bounding in-flight bursts.
// Defining RDMA2_AR_4K_SPLIT_EN splits any burst that crosses a 4 KB page into two ARs.
module rdma2_ar_issue #(
    parameter int ADDR_W          = 32,
    parameter int BEAT_BYTES      = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ap_start,
    input  logic [8:0]          burst_beats,
    rdma2_ar_issue_if.master    bus,
    output logic [3:0]          outstanding,
    output logic [15:0]         ar_count,
    output logic                idle
);
    localparam int              SIZE   = $clog2(BEAT_BYTES);
    localparam logic [ADDR_W-1:0] AMASK  = ~ADDR_W'(BEAT_BYTES - 1);
    localparam logic [3:0]      MAX_OS = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1
`ifdef RDMA2_AR_4K_SPLIT_EN
        , ISSUE2 = 2'd2
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [7:0]          arlen_q, arlen_d;
    logic                arvalid_q, arvalid_d;
    logic [3:0]          out_q, out_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                idle_q;
    logic                run_q;
    logic                pop, hs, dec;
    logic [8:0]          beats;

`ifdef RDMA2_AR_4K_SPLIT_EN
    logic [8:0]          rem_q, rem_d;
    logic [13:0]         off14, end14;
    logic [8:0]          beats1;

    assign off14  = {2'b00, bus.fifo_data[11:0] & AMASK[11:0]};
    assign end14  = off14 + 14'(int'(beats) * BEAT_BYTES);
    assign beats1 = 9'((14'd4096 - off14) >> SIZE);
`endif

    // A zero burst length is treated as a single beat.
    assign beats = (burst_beats == 9'd0) ? 9'd1 : burst_beats;
    assign hs    = arvalid_q & bus.m_axi_arready;
    assign dec   = bus.m_axi_rvalid & bus.m_axi_rready & bus.m_axi_rlast & (out_q != 4'd0);

    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arvalid_d = arvalid_q;
        pop       = 1'b0;
`ifdef RDMA2_AR_4K_SPLIT_EN
        rem_d     = rem_q;
`endif
        case (state_q)
            IDLE: begin
                // run_q keeps the pop strobe quiet while reset is being released.
                if (run_q && bus.fifo_empty_n && (out_q < MAX_OS)) begin
                    pop       = 1'b1;
                    araddr_d  = bus.fifo_data & AMASK;
                    arlen_d   = 8'(beats - 9'd1);
                    arvalid_d = 1'b1;
                    state_d   = ISSUE;
`ifdef RDMA2_AR_4K_SPLIT_EN
                    rem_d = 9'd0;
                    if (end14 > 14'd4096) begin
                        arlen_d = 8'(beats1 - 9'd1);
                        rem_d   = beats - beats1;
                    end
`endif
                end
            end
            ISSUE: begin
                if (hs) begin
                    arvalid_d = 1'b0;
                    state_d   = IDLE;
`ifdef RDMA2_AR_4K_SPLIT_EN
                    if (rem_q != 9'd0) begin
                        state_d  = ISSUE2;
                        araddr_d = {araddr_q[ADDR_W-1:12] + 1'b1, 12'h000};
                        arlen_d  = 8'(rem_q - 9'd1);
                    end
`endif
                end
            end
`ifdef RDMA2_AR_4K_SPLIT_EN
            ISSUE2: begin
                // The second half re-checks the in-flight limit before raising arvalid.
                if (!arvalid_q) begin
                    if (out_q < MAX_OS) arvalid_d = 1'b1;
                end else if (hs) begin
                    arvalid_d = 1'b0;
                    rem_d     = 9'd0;
                    state_d   = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_d = out_q;
        case ({hs, dec})
            2'b10:   out_d = out_q + 4'd1;
            2'b01:   out_d = out_q - 4'd1;
            default: out_d = out_q;
        endcase
        cnt_d = ap_start ? {15'd0, hs} : cnt_q + {15'd0, hs};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arvalid_q <= 1'b0;
            out_q     <= '0;
            cnt_q     <= '0;
            idle_q    <= 1'b1;
            run_q     <= 1'b0;
`ifdef RDMA2_AR_4K_SPLIT_EN
            rem_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arvalid_q <= arvalid_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
            idle_q    <= (state_q == IDLE) && (out_q == 4'd0) && !bus.fifo_empty_n;
            run_q     <= 1'b1;
`ifdef RDMA2_AR_4K_SPLIT_EN
            rem_q     <= rem_d;
`endif
        end
    end

    assign bus.fifo_valid    = pop;
    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arlen   = arlen_q;
    assign bus.m_axi_arsize  = 3'(SIZE);
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arvalid = arvalid_q;
    assign outstanding       = out_q;
    assign ar_count          = cnt_q;
    assign idle              = idle_q;
endmodule

// File: tb/tb_rdma2_ar_issue.sv
// Scoreboard bench for rdma2_ar_issue: directed vectors push expected ARs, a negedge monitor compares handshakes.
module tb_rdma2_ar_issue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ap_start;
    logic [8:0]  burst_beats;
    logic [3:0]  outstanding;
    logic [15:0] ar_count;
    logic        idle;

    rdma2_ar_issue_if #(.ADDR_W(32)) bus ();

    rdma2_ar_issue #(.ADDR_W(32), .BEAT_BYTES(8), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst_n(rst_n), .ap_start(ap_start), .burst_beats(burst_beats),
        .bus(bus), .outstanding(outstanding), .ar_count(ar_count), .idle(idle)
    );

    always #5 clk = ~clk;

`ifdef RDMA2_AR_4K_SPLIT_EN
    localparam int NSPLIT = 2;
`else
    localparam int NSPLIT = 1;
`endif

    typedef struct { logic [31:0] a; logic [7:0] l; } ar_t;
    ar_t         exp_q[$];
    logic [31:0] fq[$];
    int checks = 0, failures = 0;
    int hs_cnt = 0, pops = 0;
    bit pop_req = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s timed out at %0t", nm, $time);
    endtask

    function automatic void refresh();
        bus.fifo_empty_n = (fq.size() != 0);
        bus.fifo_data    = (fq.size() != 0) ? fq[0] : 32'h0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a);
        fq.push_back(a);
        refresh();
    endtask

    task automatic expect_ar(input logic [31:0] a, input logic [7:0] l);
        ar_t e;
        e.a = a;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic rlast_pulse();
        bus.m_axi_rvalid = 1'b1; bus.m_axi_rready = 1'b1; bus.m_axi_rlast = 1'b1;
        step();
        bus.m_axi_rvalid = 1'b0; bus.m_axi_rready = 1'b0; bus.m_axi_rlast = 1'b0;
    endtask

    task automatic wait_hs(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (hs_cnt >= target) return;
            @(negedge clk);
        end
        if (hs_cnt < target) timeout("wait_hs");
    endtask

    task automatic wait_arvalid(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.m_axi_arvalid === 1'b1) return;
        end
        timeout("wait_arvalid");
    endtask

    // Monitor: compare every AR handshake against the scoreboard, record pop strobes.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.fifo_valid === 1'b1) begin
                pops++;
                pop_req = 1'b1;
            end
            if (bus.m_axi_arvalid === 1'b1 && bus.m_axi_arready === 1'b1) begin
                ar_t e;
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    timeout("ar_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    chk("ar_addr", {32'h0, bus.m_axi_araddr}, {32'h0, e.a});
                    chk("ar_len", {56'h0, bus.m_axi_arlen}, {56'h0, e.l});
                    chk("ar_size_burst", {59'h0, bus.m_axi_arsize, bus.m_axi_arburst}, {59'h0, 3'd3, 2'b01});
                end
            end
        end
    end

    // FWFT FIFO model: head advances just after the edge that consumed it.
    always @(posedge clk) begin
        #1;
        if (pop_req) begin
            pop_req = 1'b0;
            if (fq.size() != 0) void'(fq.pop_front());
            refresh();
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, p0;
        logic [3:0] os_before;
        rst_n = 1'b0; ap_start = 1'b0; burst_beats = 9'd16;
        bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rready = 1'b0; bus.m_axi_rlast = 1'b0;
        refresh();
        step(); step();
        @(negedge clk);
        chk("rst_arvalid", {63'h0, bus.m_axi_arvalid}, 64'd0);
        chk("rst_fifo_valid", {63'h0, bus.fifo_valid}, 64'd0);
        chk("rst_arsize", {61'h0, bus.m_axi_arsize}, 64'd3);
        chk("rst_arburst", {62'h0, bus.m_axi_arburst}, 64'd1);
        chk("rst_outstanding", {60'h0, outstanding}, 64'd0);
        chk("rst_ar_count", {48'h0, ar_count}, 64'd0);
        chk("rst_idle", {63'h0, idle}, 64'd1);
        step();
        rst_n = 1'b1;
        step(); step();

        // Single pop with immediate accept.
        bus.m_axi_arready = 1'b1;
        expect_ar(32'h1000_0000, 8'd15);
        push(32'h1000_0000);
        @(negedge clk);
        chk("pop_strobe", {62'h0, bus.fifo_valid, bus.m_axi_arvalid}, 64'b10);
        @(negedge clk);
        chk("pop_latency", {62'h0, bus.fifo_valid, bus.m_axi_arvalid}, 64'b01);
        step();
        chk("single_ar_count", {48'h0, ar_count}, 64'd1);
        chk("single_outstanding", {60'h0, outstanding}, 64'd1);
        chk("single_pops", 64'(pops), 64'd1);
        rlast_pulse();
        chk("single_retire", {60'h0, outstanding}, 64'd0);
        step();
        chk("single_idle", {63'h0, idle}, 64'd1);

        // Unaligned address and zero burst length.
        burst_beats = 9'd0;
        expect_ar(32'h2000_0000, 8'd0);
        push(32'h2000_0005);
        wait_hs(2, 20);
        step();
        rlast_pulse();

        // Backpressure: five stalled cycles, accept on the sixth.
        base = hs_cnt; p0 = pops;
        bus.m_axi_arready = 1'b0;
        burst_beats = 9'd4;
        expect_ar(32'hA000_0040, 8'd3);
        expect_ar(32'hA000_0080, 8'd3);
        push(32'hA000_0040);
        push(32'hA000_0080);
        wait_arvalid(20);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {23'h0, bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen},
                {23'h0, 1'b1, 32'hA000_0040, 8'd3});
            chk("bp_no_pop", {63'h0, bus.fifo_valid}, 64'd0);
            if (i < 4) @(negedge clk);
        end
        chk("bp_no_hs", 64'(hs_cnt - base), 64'd0);
        step();
        bus.m_axi_arready = 1'b1;
        wait_hs(base + 2, 20);
        step();
        chk("bp_pops", 64'(pops - p0), 64'd2);
        rlast_pulse();
        rlast_pulse();

        // Outstanding limit with six queued addresses.
        base = hs_cnt;
        burst_beats = 9'd2;
        for (int i = 0; i < 6; i++) begin
            expect_ar(32'hB000_0000 + 32'(i * 256), 8'd1);
            push(32'hB000_0000 + 32'(i * 256));
        end
        repeat (20) step();
        chk("lim_issued", 64'(hs_cnt - base), 64'd4);
        chk("lim_outstanding", {60'h0, outstanding}, 64'd4);
        chk("lim_fifo_left", 64'(fq.size()), 64'd2);
        @(negedge clk);
        chk("lim_blocked", {63'h0, bus.fifo_valid}, 64'd0);
        step();
        rlast_pulse();
        wait_hs(base + 5, 20);
        step();
        chk("lim_fifth", {60'h0, outstanding}, 64'd4);
        rlast_pulse();
        wait_arvalid(20);
        os_before = outstanding;
        bus.m_axi_rvalid = 1'b1; bus.m_axi_rready = 1'b1; bus.m_axi_rlast = 1'b1;
        step();
        bus.m_axi_rvalid = 1'b0; bus.m_axi_rready = 1'b0; bus.m_axi_rlast = 1'b0;
        chk("os_simul", {60'h0, outstanding}, {60'h0, os_before});
        chk("os_simul_val", {60'h0, outstanding}, 64'd3);
        repeat (3) rlast_pulse();
        rlast_pulse();
        chk("os_saturate", {60'h0, outstanding}, 64'd0);

        // 4 KB crossing.
        base = hs_cnt; p0 = pops;
        burst_beats = 9'd32;
`ifdef RDMA2_AR_4K_SPLIT_EN
        expect_ar(32'h0000_0F80, 8'd15);
        expect_ar(32'h0000_1000, 8'd15);
`else
        expect_ar(32'h0000_0F80, 8'd31);
`endif
        push(32'h0000_0F80);
        wait_hs(base + NSPLIT, 30);
        step();
        chk("split_pops", 64'(pops - p0), 64'd1);
        chk("split_ar_count", {48'h0, ar_count}, 64'(10 + NSPLIT));
        repeat (NSPLIT) rlast_pulse();

        // ap_start clear, then ap_start coinciding with a handshake at ar_count=7.
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        chk("ap_clear", {48'h0, ar_count}, 64'd0);
        burst_beats = 9'd1;
        for (int i = 0; i < 7; i++) begin
            base = hs_cnt;
            expect_ar(32'hC000_0000 + 32'(i * 8), 8'd0);
            push(32'hC000_0000 + 32'(i * 8));
            wait_hs(base + 1, 20);
            step();
            rlast_pulse();
        end
        chk("ap_seven", {48'h0, ar_count}, 64'd7);
        bus.m_axi_arready = 1'b0;
        expect_ar(32'hD000_0000, 8'd0);
        push(32'hD000_0000);
        wait_arvalid(20);
        bus.m_axi_arready = 1'b1;
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        chk("ap_with_hs", {48'h0, ar_count}, 64'd1);
        chk("ap_outstanding", {60'h0, outstanding}, 64'd1);

        // Asynchronous reset while a burst is held in ISSUE.
        bus.m_axi_arready = 1'b0;
        burst_beats = 9'd8;
        expect_ar(32'hE000_0000, 8'd7);
        expect_ar(32'hE000_1000, 8'd7);
        push(32'hE000_0000);
        push(32'hE000_1000);
        wait_arvalid(20);
        rst_n = 1'b0;
        #1;
        chk("arst_arvalid", {63'h0, bus.m_axi_arvalid}, 64'd0);
        chk("arst_outstanding", {60'h0, outstanding}, 64'd0);
        chk("arst_ar_count", {48'h0, ar_count}, 64'd0);
        void'(exp_q.pop_front());
        step(); step();
        rst_n = 1'b1;
        bus.m_axi_arready = 1'b1;
        base = hs_cnt;
        wait_hs(base + 1, 20);
        step();
        chk("arst_resume", {60'h0, outstanding}, 64'd1);
        chk("arst_resume_cnt", {48'h0, ar_count}, 64'd1);
        rlast_pulse();
        repeat (3) step();
        chk("final_idle", {63'h0, idle}, 64'd1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
